// File: rtl/spike_readout_wta.sv
// spike_readout_wta: windowed spike-count readout with winner-take-all scan.
// Counts spikes per channel for WINDOW cycles after an accepted start. It then
// scans the counters one channel per cycle for the maximum, and presents the
// winning index and its count.
// Optional feature macro: SPIKE_READOUT_SAT_EN. When it is defined, the counters
// saturate and sat_o is sticky. When it is not defined, the counters wrap and
// sat_o is tied to 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start_i; last result and counts held
// S_COUNT | sampling spike_i for WINDOW edges
// S_SCAN  | comparing one channel counter per cycle against the best so far
// S_DONE  | registering the result; done_o pulses on the edge leaving it
module spike_readout_wta #(
    parameter int NUM_CH = 10,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 64,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] spike_i,
    input  logic [IDX_W-1:0]  count_sel_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    output logic [IDX_W-1:0]  winner_o,
    output logic [CNT_W-1:0]  winner_count_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              sat_o
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SCAN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              clear, count_en, scan_en, finish;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [WIN_W-1:0]  win_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [CNT_W-1:0]  best_cnt_q;
    logic              done_q;

    // done_o is registered with the result, so the pulse cycle is already back in
    // IDLE. Busy is stretched over that cycle, and start is refused during it, so
    // a new run begins only in the cycle after the pulse.
    assign done_o = done_q;
    assign busy_o = (state_q != S_IDLE) || done_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        count_en = 1'b0;
        scan_en  = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !done_q) begin
                    clear   = 1'b1;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                count_en = 1'b1;
                if (win_q == WIN_LAST) state_d = S_SCAN;
            end
            S_SCAN: begin
                scan_en = 1'b1;
                if (idx_q == IDX_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-channel spike counters and window counter
`ifdef SPIKE_READOUT_SAT_EN
    logic sat_q;
    assign sat_o = sat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
            win_q <= '0;
            sat_q <= 1'b0;
        end else if (clear) begin
            for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
            win_q <= '0;
            sat_q <= 1'b0;
        end else if (count_en) begin
            win_q <= win_q + 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (spike_i[ch]) begin
                    if (cnt_q[ch] == '1) sat_q <= 1'b1;
                    else                 cnt_q[ch] <= cnt_q[ch] + 1'b1;
                end
            end
        end
    end
`else
    assign sat_o = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
            win_q <= '0;
        end else if (clear) begin
            for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
            win_q <= '0;
        end else if (count_en) begin
            win_q <= win_q + 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (spike_i[ch]) cnt_q[ch] <= cnt_q[ch] + 1'b1;
            end
        end
    end
`endif

    // Sequential max scan and result registers; strict compare keeps the lowest index on ties
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q          <= '0;
            best_idx_q     <= '0;
            best_cnt_q     <= '0;
            done_q         <= 1'b0;
            valid_o        <= 1'b0;
            winner_o       <= '0;
            winner_count_o <= '0;
        end else begin
            done_q <= finish;
            if (clear) begin
                idx_q      <= '0;
                best_idx_q <= '0;
                best_cnt_q <= '0;
                valid_o    <= 1'b0;
            end
            if (scan_en) begin
                if (cnt_q[idx_q] > best_cnt_q) begin
                    best_cnt_q <= cnt_q[idx_q];
                    best_idx_q <= idx_q;
                end
                idx_q <= idx_q + 1'b1;
            end
            if (finish) begin
                winner_o       <= best_idx_q;
                winner_count_o <= best_cnt_q;
                valid_o        <= 1'b1;
            end
        end
    end

    // Count readback; out-of-range selects read as zero
    always_comb begin
        count_o = '0;
        if (32'(count_sel_i) < 32'(NUM_CH)) count_o = cnt_q[count_sel_i];
    end

endmodule
